// File: rtl/fft_frame_feeder.sv
// Ping-pong frame feeder: collects ADC samples into two N-word banks and streams
// each full bank to the FFT sink interface with sop/eop under ready backpressure.
`timescale 1ns/1ps
module fft_frame_feeder #(
   parameter int FFT_N      = 256,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int OFFSET_BIN = 0
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic              sink_ready,
   output logic [DATA_W-1:0] sink_real,
   output logic [DATA_W-1:0] sink_imag,
   output logic              sink_sop,
   output logic              sink_eop,
   output logic              sink_valid,
   output logic              overrun,
   output logic [15:0]       frame_cnt
);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

   state_t              state, state_nx;
   logic [DATA_W-1:0]   mem [2*FFT_N];
   logic [DATA_W-1:0]   wdata, rdata, out_q;
   logic [1:0]          full;
   logic                wr_bank, rd_bank;
   logic [ADDR_W-1:0]   wr_addr, rd_addr, beat;
   logic                prime_ph, prime_ph_nx;
   logic                we, ren, ld, done, xfer, last;

   generate
      if (OFFSET_BIN != 0) begin : g_conv
         assign wdata = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
      end else begin : g_pass
         assign wdata = adc_data;
      end
   endgenerate

   assign we   = adc_valid && !full[wr_bank];
   assign xfer = sink_valid && sink_ready;
   assign last = (beat == ADDR_W'(FFT_N-1));

   // rdata always holds the word after the one on the output, so a transfer
   // every cycle never starves regardless of how ready toggles.
   always_comb begin
      state_nx    = state;
      prime_ph_nx = prime_ph;
      ren         = 1'b0;
      ld          = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_nx    = PRIME;
               prime_ph_nx = 1'b0;
            end
         end
         PRIME: begin
            ren = 1'b1;
            if (prime_ph) begin
               ld       = 1'b1;
               state_nx = STREAM;
            end else begin
               prime_ph_nx = 1'b1;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (last) begin
                  done     = 1'b1;
                  state_nx = IDLE;
               end else begin
                  ren = 1'b1;
                  ld  = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prime_ph <= 1'b0;
      end else begin
         state    <= state_nx;
         prime_ph <= prime_ph_nx;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (we)  mem[{wr_bank, wr_addr}] <= wdata;
      if (ren) rdata <= mem[{rd_bank, rd_addr}];
   end

   // Drop decision uses the registered full flag, so a same-cycle clear loses.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
         wr_bank <= 1'b0;
         full    <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= adc_valid && full[wr_bank];
         if (we) begin
            if (wr_addr == ADDR_W'(FFT_N-1)) begin
               wr_addr       <= '0;
               wr_bank       <= ~wr_bank;
               full[wr_bank] <= 1'b1;
            end else begin
               wr_addr <= wr_addr + ADDR_W'(1);
            end
         end
         if (done) full[rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr    <= '0;
         rd_bank    <= 1'b0;
         beat       <= '0;
         out_q      <= '0;
         sink_valid <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         if (ren) rd_addr <= rd_addr + ADDR_W'(1);
         if (ld) begin
            out_q      <= rdata;
            sink_valid <= 1'b1;
            if (state == STREAM) beat <= beat + ADDR_W'(1);
         end
         if (done) begin
            rd_addr    <= '0;
            beat       <= '0;
            sink_valid <= 1'b0;
            rd_bank    <= ~rd_bank;
            frame_cnt  <= frame_cnt + 16'd1;
         end
      end
   end

   assign sink_real = out_q;
   assign sink_imag = '0;
   assign sink_sop  = sink_valid && (beat == '0);
   assign sink_eop  = sink_valid && last;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: ramp/latency, offset-binary conversion,
// backpressure, overrun, gappy input and mid-frame reset.
`timescale 1ns/1ps
module tb_fft_frame_feeder;
   localparam int N = 256;

   logic        clk_50m = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic        sink_ready = 1'b0;

   logic [15:0] r0, i0, fc0, r1, i1, fc1;
   logic        sop0, eop0, v0, o0, sop1, eop1, v1, o1;

   int n_chk = 0, n_err = 0;
   int rmode = 0;
   logic rlvl = 1'b0;
   int ovr_cnt = 0;
   logic [17:0] rx[$];
   logic [15:0] rx1[$];

   fft_frame_feeder #(.OFFSET_BIN(0)) dut0 (
      .clk_50m(clk_50m), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
      .sink_ready(sink_ready), .sink_real(r0), .sink_imag(i0), .sink_sop(sop0),
      .sink_eop(eop0), .sink_valid(v0), .overrun(o0), .frame_cnt(fc0));

   fft_frame_feeder #(.OFFSET_BIN(1)) dut1 (
      .clk_50m(clk_50m), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
      .sink_ready(sink_ready), .sink_real(r1), .sink_imag(i1), .sink_sop(sop1),
      .sink_eop(eop1), .sink_valid(v1), .overrun(o1), .frame_cnt(fc1));

   always #10 clk_50m = ~clk_50m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ready: 0 = hold rlvl, 1 = toggle, 2 = random
   always @(posedge clk_50m) begin
      #1;
      case (rmode)
         1:       sink_ready = ~sink_ready;
         2:       sink_ready = 1'($urandom_range(0, 1));
         default: sink_ready = rlvl;
      endcase
   end

   logic        p_stall = 1'b0, p_sop = 1'b0, p_eop = 1'b0;
   logic [15:0] p_d = '0;
   always @(negedge clk_50m) begin
      if (!rst_n) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            check("stall_valid", 32'(v0), 32'd1);
            check("stall_data", 32'(r0), 32'(p_d));
            check("stall_sop_eop", 32'({sop0, eop0}), 32'({p_sop, p_eop}));
         end
         if (!v0) check("idle_sop_eop", 32'({sop0, eop0}), 32'd0);
         if (v0 && sink_ready) begin
            rx.push_back({sop0, eop0, r0});
            check("imag", 32'({i0, i1}), 32'd0);
         end
         if (v1 && sink_ready) rx1.push_back(r1);
         if (o0) ovr_cnt++;
         p_stall = v0 && !sink_ready;
         p_d = r0; p_sop = sop0; p_eop = eop0;
      end
   end

   function automatic logic [17:0] beat_at(input int k);
      return (k < rx.size()) ? rx[k] : 18'hxxxxx;
   endfunction

   task automatic do_reset();
      @(posedge clk_50m); #1;
      rst_n = 1'b0; adc_valid = 1'b0; rmode = 0; rlvl = 1'b0;
      #1;
      check("rst_valid", 32'(v0), 32'd0);
      check("rst_sop_eop", 32'({sop0, eop0}), 32'd0);
      check("rst_real", 32'(r0), 32'd0);
      check("rst_fcnt", 32'(fc0), 32'd0);
      check("rst_ovr", 32'(o0), 32'd0);
      repeat (2) @(posedge clk_50m);
      #1 rst_n = 1'b1;
      rx.delete(); rx1.delete(); ovr_cnt = 0;
   endtask

   task automatic feed(input int base, input int cnt, input int gap);
      for (int i = 0; i < cnt; i++) begin
         @(posedge clk_50m); #1;
         adc_data = 16'(base + i); adc_valid = 1'b1;
         repeat (gap) begin @(posedge clk_50m); #1 adc_valid = 1'b0; end
      end
      @(posedge clk_50m); #1 adc_valid = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget);
      int c = 0;
      while (rx.size() < n && c < budget) begin @(posedge clk_50m); c++; end
      repeat (3) @(posedge clk_50m);
      #1 check("beat_count", 32'(rx.size()), 32'(n));
   endtask

   task automatic check_frame(input string tag, input int off, input int base);
      logic [17:0] b;
      for (int i = 0; i < N; i++) begin
         b = beat_at(off + i);
         check({tag, "_data"}, 32'(b[15:0]), 32'(16'(base + i)));
         check({tag, "_sop_eop"}, 32'(b[17:16]), 32'({i == 0, i == N-1}));
      end
   endtask

   logic [15:0] conv_in [4]  = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
   logic [15:0] conv_exp [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};

   initial begin
      int lat, run, c;

      // ramp with latency and run length
      do_reset(); rlvl = 1'b1;
      for (int i = 0; i < N; i++) begin
         @(posedge clk_50m); #1 adc_data = 16'(i); adc_valid = 1'b1;
      end
      @(posedge clk_50m); #1 adc_valid = 1'b0;
      lat = 0;
      while (!v0 && lat < 10) begin @(posedge clk_50m); #1; lat++; end
      check("latency", 32'(lat), 32'd3);
      run = 0;
      while (v0 && run < 1000) begin run++; @(posedge clk_50m); #1; end
      check("run_len", 32'(run), 32'(N));
      wait_beats(N, 100);
      check_frame("ramp", 0, 0);
      check("ramp_fcnt", 32'(fc0), 32'd1);

      // offset-binary conversion on dut1, raw on dut0
      do_reset(); rlvl = 1'b1;
      for (int i = 0; i < N; i++) begin
         @(posedge clk_50m); #1;
         adc_data = (i < 4) ? conv_in[i] : 16'(i); adc_valid = 1'b1;
      end
      @(posedge clk_50m); #1 adc_valid = 1'b0;
      wait_beats(N, 400);
      for (int i = 0; i < 4; i++) begin
         check("conv_ob", 32'((i < rx1.size()) ? rx1[i] : 16'hxxxx), 32'(conv_exp[i]));
         check("conv_raw", 32'(beat_at(i)), 32'({i == 0, 1'b0, conv_in[i]}));
      end

      // toggling ready
      do_reset(); rmode = 1;
      feed(0, N, 0);
      wait_beats(N, 2000);
      check_frame("bp_toggle", 0, 0);
      check("bp_toggle_fcnt", 32'(fc0), 32'd1);

      // random ready
      do_reset(); rmode = 2;
      feed(0, N, 0);
      wait_beats(N, 3000);
      check_frame("bp_rand", 0, 0);
      check("bp_rand_fcnt", 32'(fc0), 32'd1);

      // overrun: both banks fill, third bank-worth dropped
      do_reset(); rlvl = 1'b0;
      feed(0, 3*N, 0);
      repeat (5) @(posedge clk_50m);
      #1;
      check("ovr_pulses", 32'(ovr_cnt), 32'(N));
      check("ovr_no_xfer", 32'(rx.size()), 32'd0);
      check("ovr_hold", 32'({v0, sop0, r0}), 32'({1'b1, 1'b1, 16'd0}));
      rlvl = 1'b1;
      wait_beats(2*N, 3000);
      check_frame("ovr_f0", 0, 0);
      check_frame("ovr_f1", N, N);
      check("ovr_fcnt", 32'(fc0), 32'd2);

      // gappy input
      do_reset(); rlvl = 1'b1;
      feed(0, 2*N, 2);
      wait_beats(2*N, 1000);
      check_frame("gap_f0", 0, 0);
      check_frame("gap_f1", N, N);
      check("gap_ovr", 32'(ovr_cnt), 32'd0);
      check("gap_fcnt", 32'(fc0), 32'd2);

      // reset while beat 100 is on the output
      do_reset(); rlvl = 1'b1;
      feed(0, N, 0);
      c = 0;
      while (!(v0 && r0 == 16'd100) && c < 1000) begin @(posedge clk_50m); #1; c++; end
      check("mid_reach", 32'(r0), 32'd100);
      #4 rst_n = 1'b0;
      #1;
      check("mid_rst_out", 32'({v0, sop0, eop0, o0}), 32'd0);
      check("mid_rst_data", 32'({r0, fc0}), 32'd0);
      repeat (2) @(posedge clk_50m);
      #1 rst_n = 1'b1;
      rx.delete(); rx1.delete(); ovr_cnt = 0;
      feed(0, N, 0);
      wait_beats(N, 400);
      repeat (20) @(posedge clk_50m);
      #1 check("mid_only_one", 32'(rx.size()), 32'(N));
      check_frame("mid_frame", 0, 0);
      check("mid_fcnt", 32'(fc0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
